commit_ctrl: RTL and testbench

In-order retirement controller between the ROB head and the architectural register file's single commit port. Each cycle it inspects the ROB head entry, decides whether it can retire, drives the register-file commit strobe (`sgn`/dest/value/ROB name), sequences store retirement through a request/ack handshake with the LSB, and raises a one-cycle pipeline flush on branch mispredict. It is the only writer of the register file's commit port and the only source of `ROB_pop`.

---
 rtl/commit_ctrl.sv | 97 +++++++++
 tb/tb_commit_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order ROB retirement into the register-file commit port, store handshake and mispredict flush.
// Define COMMIT_CNT_EN to add the retired-instruction counter on commit_cnt.
module commit_ctrl #(
    parameter int ROB_W = 4,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             ROB_head_vld,
    input  logic             ROB_head_done,
    input  logic [1:0]       ROB_head_type,
    input  logic [REG_W-1:0] ROB_head_dest,
    input  logic [31:0]      ROB_head_val,
    input  logic [ROB_W-1:0] ROB_head_name,
    input  logic             ROB_head_mispred,
    input  logic [31:0]      ROB_head_npc,
    output logic             ROB_pop,
    output logic             REG_commit_sgn,
    output logic [REG_W-1:0] REG_commit_dest,
    output logic [31:0]      REG_commit_value,
    output logic [ROB_W-1:0] REG_commit_ROB_name,
    output logic             LSB_store_req,
    output logic [ROB_W-1:0] LSB_store_name,
    input  logic             LSB_store_ack,
    output logic             FLUSH_sgn,
    output logic [31:0]      FLUSH_pc,
    output logic             halted,
    output logic [31:0]      commit_cnt
);
    typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH, HALT} state_t;
    state_t state;
    logic ready;
    always_comb begin
        ready   = rdy && ROB_head_vld && ROB_head_done;
        ROB_pop = state == RUN ? ready && ROB_head_type != 2'd1
                               : state == STORE_WAIT && rdy && LSB_store_ack;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= RUN;
            REG_commit_sgn      <= 1'b0;
            REG_commit_dest     <= '0;
            REG_commit_value    <= '0;
            REG_commit_ROB_name <= '0;
            LSB_store_req       <= 1'b0;
            LSB_store_name      <= '0;
            FLUSH_sgn           <= 1'b0;
            FLUSH_pc            <= '0;
            halted              <= 1'b0;
        end else if (rdy) begin
            REG_commit_sgn <= 1'b0;
            FLUSH_sgn      <= 1'b0;
            case (state)
                RUN: if (ready) begin
                    case (ROB_head_type)
                        2'd1: begin
                            LSB_store_req  <= 1'b1;
                            LSB_store_name <= ROB_head_name;
                            state          <= STORE_WAIT;
                        end
                        2'd3: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: begin
                            // writes to x0 retire but never strobe the register file
                            REG_commit_sgn      <= ROB_head_dest != '0;
                            REG_commit_dest     <= ROB_head_dest;
                            REG_commit_value    <= ROB_head_val;
                            REG_commit_ROB_name <= ROB_head_name;
                            if (ROB_head_type == 2'd2 && ROB_head_mispred) begin
                                FLUSH_sgn <= 1'b1;
                                FLUSH_pc  <= ROB_head_npc;
                                state     <= FLUSH;
                            end
                        end
                    endcase
                end
                STORE_WAIT: if (LSB_store_ack) begin
                    LSB_store_req <= 1'b0;
                    state         <= RUN;
                end
                FLUSH:   state <= RUN;
                default: state <= HALT;
            endcase
        end
    end
`ifdef COMMIT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) commit_cnt <= '0;
        else if (ROB_pop) commit_cnt <= commit_cnt + 32'd1;
    end
`else
    assign commit_cnt = '0;
`endif
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: scenario tasks with a commit scoreboard for commit_ctrl.
module tb_commit_ctrl;
`ifdef COMMIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk = 0, rst = 1, rdy = 1;
    logic vld = 0, done = 0, mis = 0, ack = 0;
    logic [1:0] typ = 0;
    logic [4:0] dst = 0;
    logic [31:0] val = 0, npc = 0;
    logic [3:0] nm = 0;
    logic pop, sgn, req, fsgn, hlt;
    logic [4:0] cdest;
    logic [31:0] cval, fpc, cnt;
    logic [3:0] cname, sname;
    int compared = 0, mismatched = 0;
    logic fresh = 0;
    typedef struct {logic [4:0] d; logic [31:0] v; logic [3:0] n;} exp_t;
    exp_t q[$];

    commit_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ROB_head_vld(vld), .ROB_head_done(done), .ROB_head_type(typ),
        .ROB_head_dest(dst), .ROB_head_val(val), .ROB_head_name(nm),
        .ROB_head_mispred(mis), .ROB_head_npc(npc), .ROB_pop(pop),
        .REG_commit_sgn(sgn), .REG_commit_dest(cdest), .REG_commit_value(cval),
        .REG_commit_ROB_name(cname), .LSB_store_req(req), .LSB_store_name(sname),
        .LSB_store_ack(ack), .FLUSH_sgn(fsgn), .FLUSH_pc(fpc),
        .halted(hlt), .commit_cnt(cnt)
    );

    always #5 clk = ~clk;

    // a strobe is new only if the edge that produced it was enabled
    always @(posedge clk) fresh = rdy || rst;
    always @(negedge clk) begin
        if (fresh && !rst && sgn) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL commit_unexpected: got dest=%0d val=%h name=%0d, expected none", cdest, cval, cname);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({cdest, cval, cname} !== {e.d, e.v, e.n}) begin
                    mismatched++;
                    $display("FAIL commit_data: got dest=%0d val=%h name=%0d, expected dest=%0d val=%h name=%0d",
                             cdest, cval, cname, e.d, e.v, e.n);
                end
            end
        end
        fresh = 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic [1:0] t, input logic [4:0] d, input logic [31:0] v,
                            input logic [3:0] n, input logic m, input logic [31:0] p);
        vld = 1; done = 1; typ = t; dst = d; val = v; nm = n; mis = m; npc = p;
    endtask

    task automatic idle;
        vld = 0; done = 0; typ = 0; dst = 0; val = 0; nm = 0; mis = 0; npc = 0;
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v, input logic [3:0] n);
        exp_t e;
        e.d = d; e.v = v; e.n = n;
        q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1;
        set_head(2'd0, 5'd4, 32'h55, 4'd1, 1'b0, 32'h0);
        tick;
        tick;
        compared++;
        if ({sgn, req, fsgn, hlt, cdest, cval, cname, sname, fpc, cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got sgn=%b req=%b flush=%b halted=%b cnt=%0d, expected all 0", sgn, req, fsgn, hlt, cnt);
        end
        idle;
        rst = 0;
        #1;
        compared++;
        if (pop !== 1'b0) begin mismatched++; $display("FAIL reset_pop: got %b expected 0", pop); end
        tick;
    endtask

    task automatic test_alu;
        set_head(2'd0, 5'd5, 32'h1234, 4'd3, 1'b0, 32'h0);
        #1;
        compared++;
        if (pop !== 1'b1) begin mismatched++; $display("FAIL alu_pop: got %b expected 1", pop); end
        push(5'd5, 32'h1234, 4'd3);
        tick;
        idle;
        #1;
        compared++;
        if (pop !== 1'b0 || sgn !== 1'b1) begin
            mismatched++; $display("FAIL alu_strobe: got pop=%b sgn=%b expected pop=0 sgn=1", pop, sgn);
        end
        tick;
        compared++;
        if (sgn !== 1'b0) begin mismatched++; $display("FAIL alu_pulse: got sgn=%b expected 0", sgn); end
    endtask

    task automatic test_x0;
        set_head(2'd0, 5'd0, 32'hFFFF, 4'd2, 1'b0, 32'h0);
        #1;
        compared++;
        if (pop !== 1'b1) begin mismatched++; $display("FAIL x0_pop: got %b expected 1", pop); end
        tick;
        idle;
        compared++;
        if (sgn !== 1'b0) begin mismatched++; $display("FAIL x0_sgn: got %b expected 0", sgn); end
        tick;
    endtask

    task automatic test_store;
        set_head(2'd1, 5'd9, 32'h77, 4'd7, 1'b0, 32'h0);
        #1;
        compared++;
        if (pop !== 1'b0) begin mismatched++; $display("FAIL store_issue_pop: got %b expected 0", pop); end
        tick;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (req !== 1'b1 || sname !== 4'd7 || pop !== 1'b0 || sgn !== 1'b0) begin
                mismatched++;
                $display("FAIL store_wait[%0d]: got req=%b name=%0d pop=%b sgn=%b expected req=1 name=7 pop=0 sgn=0", i, req, sname, pop, sgn);
            end
            tick;
        end
        ack = 1;
        #1;
        compared++;
        if (pop !== 1'b1) begin mismatched++; $display("FAIL store_ack_pop: got %b expected 1", pop); end
        tick;
        ack = 0;
        idle;
        compared++;
        if (req !== 1'b0 || sgn !== 1'b0) begin
            mismatched++; $display("FAIL store_done: got req=%b sgn=%b expected 0 0", req, sgn);
        end
        ack = 1;
        #1;
        compared++;
        if (pop !== 1'b0) begin mismatched++; $display("FAIL stray_ack_pop: got %b expected 0", pop); end
        tick;
        ack = 0;
        compared++;
        if (req !== 1'b0) begin mismatched++; $display("FAIL stray_ack_req: got %b expected 0", req); end
    endtask

    task automatic test_mispredict;
        set_head(2'd2, 5'd1, 32'h100, 4'd5, 1'b1, 32'h2000);
        #1;
        compared++;
        if (pop !== 1'b1) begin mismatched++; $display("FAIL mis_pop: got %b expected 1", pop); end
        push(5'd1, 32'h100, 4'd5);
        tick;
        set_head(2'd0, 5'd2, 32'h22, 4'd6, 1'b0, 32'h0);
        compared++;
        if (fsgn !== 1'b1 || fpc !== 32'h2000 || sgn !== 1'b1) begin
            mismatched++;
            $display("FAIL mis_flush: got flush=%b pc=%h sgn=%b expected 1 00002000 1", fsgn, fpc, sgn);
        end
        #1;
        compared++;
        if (pop !== 1'b0) begin mismatched++; $display("FAIL flush_pop: got %b expected 0", pop); end
        tick;
        #1;
        compared++;
        if (fsgn !== 1'b0 || pop !== 1'b1) begin
            mismatched++; $display("FAIL post_flush: got flush=%b pop=%b expected 0 1", fsgn, pop);
        end
        push(5'd2, 32'h22, 4'd6);
        tick;
        idle;
        tick;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = $urandom;
            set_head(2'd0, 5'(i + 3), v, 4'(i + 8), 1'b0, 32'h0);
            #1;
            compared++;
            if (pop !== 1'b1) begin mismatched++; $display("FAIL b2b_pop[%0d]: got %b expected 1", i, pop); end
            push(5'(i + 3), v, 4'(i + 8));
            tick;
        end
        idle;
        tick;
        compared++;
        if (sgn !== 1'b0 || q.size() != 0) begin
            mismatched++; $display("FAIL b2b_drain: got sgn=%b pending=%0d expected 0 0", sgn, q.size());
        end
    endtask

    task automatic test_counter;
        rst = 1;
        tick;
        rst = 0;
        set_head(2'd0, 5'd3, 32'h1, 4'd1, 1'b0, 32'h0);
        push(5'd3, 32'h1, 4'd1);
        tick;
        set_head(2'd1, 5'd0, 32'h0, 4'd2, 1'b0, 32'h0);
        tick;
        ack = 1;
        tick;
        ack = 0;
        set_head(2'd2, 5'd0, 32'h0, 4'd3, 1'b0, 32'h40);
        tick;
        set_head(2'd0, 5'd4, 32'h2, 4'd4, 1'b0, 32'h0);
        push(5'd4, 32'h2, 4'd4);
        tick;
        idle;
        compared++;
        if (cnt !== (CNT_EN ? 32'd4 : 32'd0)) begin
            mismatched++; $display("FAIL commit_cnt: got %0d expected %0d", cnt, CNT_EN ? 4 : 0);
        end
        set_head(2'd1, 5'd0, 32'h0, 4'd9, 1'b0, 32'h0);
        tick;
        rst = 1;
        tick;
        rst = 0;
        idle;
        compared++;
        if ({req, sname, sgn, fsgn, cnt} !== '0) begin
            mismatched++; $display("FAIL rst_abort: got req=%b name=%0d sgn=%b flush=%b cnt=%0d expected all 0", req, sname, sgn, fsgn, cnt);
        end
        tick;
    endtask

    task automatic test_stall_halt;
        set_head(2'd0, 5'd9, 32'hABCD, 4'd2, 1'b0, 32'h0);
        push(5'd9, 32'hABCD, 4'd2);
        tick;
        rdy = 0;
        set_head(2'd0, 5'd10, 32'h5, 4'd3, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick;
            compared++;
            if (pop !== 1'b0 || sgn !== 1'b1 || cdest !== 5'd9 || cval !== 32'hABCD) begin
                mismatched++;
                $display("FAIL stall[%0d]: got pop=%b sgn=%b dest=%0d val=%h expected 0 1 9 0000abcd", i, pop, sgn, cdest, cval);
            end
        end
        idle;
        rdy = 1;
        tick;
        compared++;
        if (sgn !== 1'b0) begin mismatched++; $display("FAIL stall_release: got sgn=%b expected 0", sgn); end
        set_head(2'd3, 5'd0, 32'h0, 4'd4, 1'b0, 32'h0);
        #1;
        compared++;
        if (pop !== 1'b1) begin mismatched++; $display("FAIL halt_pop: got %b expected 1", pop); end
        tick;
        set_head(2'd0, 5'd6, 32'h66, 4'd5, 1'b0, 32'h0);
        repeat (3) tick;
        compared++;
        if (hlt !== 1'b1 || pop !== 1'b0 || sgn !== 1'b0) begin
            mismatched++; $display("FAIL halted: got halted=%b pop=%b sgn=%b expected 1 0 0", hlt, pop, sgn);
        end
        idle;
        rst = 1;
        tick;
        rst = 0;
        compared++;
        if (hlt !== 1'b0) begin mismatched++; $display("FAIL halt_reset: got %b expected 0", hlt); end
        tick;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_x0;
        test_store;
        test_mispredict;
        test_back_to_back;
        test_counter;
        test_stall_halt;
        compared++;
        if (q.size() != 0) begin mismatched++; $display("FAIL scoreboard_left: got %0d pending expected 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
